// File: rtl/ternary_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ternary_serial_adder_pkg
// Description : Trit codes, FSM state encodings and half-adder result type
//               shared by the serial ternary adder and its half adder.
// Revision    : 1.0
// ============================================================================
package ternary_serial_adder_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t c_T0   = 2'b00;
    localparam trit_t c_T1   = 2'b01;
    localparam trit_t c_T2   = 2'b10;
    localparam trit_t c_TINV = 2'b11;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PASS_AB = 2'd1;
    localparam logic [1:0] c_PASS_C  = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    typedef struct packed {
        trit_t sum;
        logic  carry;
    } ha_out_t;

    // The invalid code is folded to zero so the datapath stays defined;
    // the result is discarded anyway whenever an operand was invalid.
    function automatic trit_t trit_clean(input trit_t t);
        return (t == c_TINV) ? c_T0 : t;
    endfunction

endpackage : ternary_serial_adder_pkg
`default_nettype wire

// File: rtl/ternary_serial_adder_half.sv
`default_nettype none
// ============================================================================
// Module      : ternary_half_adder
// Description : Combinational one-trit adder: (x + y) mod 3 with carry.
// Revision    : 1.0
// ============================================================================
module ternary_half_adder
    import ternary_serial_adder_pkg::*;
(
    input  logic [1:0] x,
    input  logic [1:0] y,
    output ha_out_t    result
);

    trit_t      w_x;
    trit_t      w_y;
    logic [2:0] w_total;

    always_comb begin
        w_x     = trit_clean(x);
        w_y     = trit_clean(y);
        w_total = {1'b0, w_x} + {1'b0, w_y};
        result  = '{sum: c_T0, carry: 1'b0};
        case (w_total)
            3'd0:    result = '{sum: c_T0, carry: 1'b0};
            3'd1:    result = '{sum: c_T1, carry: 1'b0};
            3'd2:    result = '{sum: c_T2, carry: 1'b0};
            3'd3:    result = '{sum: c_T0, carry: 1'b1};
            3'd4:    result = '{sum: c_T1, carry: 1'b1};
            default: result = '{sum: c_T0, carry: 1'b0};
        endcase
    end

endmodule : ternary_half_adder
`default_nettype wire

// File: rtl/ternary_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : ternary_serial_adder
// Description : Bit-serial (trit-serial) adder using one time-shared ternary
//               half adder, two passes per trit, result after 2*N_TRITS+1.
// Revision    : 1.0
// ============================================================================
module ternary_serial_adder
    import ternary_serial_adder_pkg::*;
#(
    parameter int N_TRITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2*N_TRITS-1:0]   a,
    input  logic [2*N_TRITS-1:0]   b,
    output logic                   ready,
    output logic                   done,
    output logic [2*N_TRITS-1:0]   sum,
    output logic                   carry_out,
    output logic                   err
);

    localparam int IDX_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_TRITS - 1);

    logic [1:0]           r_state;
    logic [2*N_TRITS-1:0] r_a;
    logic [2*N_TRITS-1:0] r_b;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_carry;
    trit_t                r_part_s;
    logic                 r_carry_a;
    logic                 r_err_pend;

    logic [N_TRITS-1:0]   w_inv_a;
    logic [N_TRITS-1:0]   w_inv_b;
    logic                 w_any_inv;
    trit_t                w_a_trit;
    trit_t                w_b_trit;
    trit_t                w_ha_x;
    trit_t                w_ha_y;
    ha_out_t              w_ha;

    for (genvar gi = 0; gi < N_TRITS; gi++) begin : g_inv
        assign w_inv_a[gi] = (a[2*gi +: 2] == c_TINV);
        assign w_inv_b[gi] = (b[2*gi +: 2] == c_TINV);
    end

    assign w_any_inv = |{w_inv_a, w_inv_b};
    assign ready     = (r_state == c_IDLE);

    assign w_a_trit = r_a[{r_idx, 1'b0} +: 2];
    assign w_b_trit = r_b[{r_idx, 1'b0} +: 2];

    // First pass adds the operand trits, second pass folds in the carry.
    always_comb begin
        w_ha_x = w_a_trit;
        w_ha_y = w_b_trit;
        if (r_state == c_PASS_C) begin
            w_ha_x = r_part_s;
            w_ha_y = {1'b0, r_carry};
        end
    end

    ternary_half_adder u_half_adder (
        .x      (w_ha_x),
        .y      (w_ha_y),
        .result (w_ha)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_part_s   <= c_T0;
            r_carry_a  <= 1'b0;
            r_err_pend <= 1'b0;
            done       <= 1'b0;
            sum        <= '0;
            carry_out  <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_idx      <= '0;
                        r_carry    <= 1'b0;
                        r_err_pend <= w_any_inv;
                        sum        <= '0;
                        carry_out  <= 1'b0;
                        err        <= 1'b0;
                        r_state    <= c_PASS_AB;
                    end
                end
                c_PASS_AB: begin
                    r_part_s  <= w_ha.sum;
                    r_carry_a <= w_ha.carry;
                    r_state   <= c_PASS_C;
                end
                c_PASS_C: begin
                    sum[{r_idx, 1'b0} +: 2] <= w_ha.sum;
                    // At most one of the two passes can carry.
                    r_carry <= r_carry_a | w_ha.carry;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= c_PASS_AB;
                    end
                end
                c_DONE: begin
                    done      <= 1'b1;
                    err       <= r_err_pend;
                    carry_out <= r_err_pend ? 1'b0 : r_carry;
                    if (r_err_pend) begin
                        sum <= '0;
                    end
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule : ternary_serial_adder
`default_nettype wire

// File: tb/tb_ternary_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ternary_serial_adder
// Description : Directed self-checking bench for ternary_serial_adder.
// Revision    : 1.0
// ============================================================================
module tb_ternary_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    ternary_serial_adder #(.N_TRITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call just after a falling edge; start is taken on the next rising edge.
    task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] esum, input logic ec, input logic ee);
        int lat;
        lat   = 0;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check({tag, " busy_ready"}, {31'd0, ready}, 32'd0);
                check({tag, " clr_sum"}, {24'd0, sum}, 32'd0);
                check({tag, " clr_carry"}, {31'd0, carry_out}, 32'd0);
                check({tag, " clr_err"}, {31'd0, err}, 32'd0);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, 32'd9);
        check({tag, " sum"}, {24'd0, sum}, {24'd0, esum});
        check({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, ec});
        check({tag, " err"}, {31'd0, err}, {31'd0, ee});
        check({tag, " ready_at_done"}, {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " sum_held"}, {24'd0, sum}, {24'd0, esum});
        a = 8'h00;
        b = 8'h00;
    endtask

    initial begin
        int ndone;
        int lat;
        logic [7:0] got_sum;
        logic       got_c;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #1;
        check("rst ready", {31'd0, ready}, 32'd1);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst sum", {24'd0, sum}, 32'd0);
        check("rst carry", {31'd0, carry_out}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk); run_add("1+2",       8'b00_00_00_01, 8'b00_00_00_10, 8'b00_00_01_00, 1'b0, 1'b0);
        @(negedge clk); run_add("2222+2222", 8'b10_10_10_10, 8'b10_10_10_10, 8'b10_10_10_01, 1'b1, 1'b0);
        @(negedge clk); run_add("wrap",      8'b00_00_00_01, 8'b10_10_10_10, 8'h00,         1'b1, 1'b0);
        @(negedge clk); run_add("inv_a",     8'b00_11_00_01, 8'b00_00_00_01, 8'h00,         1'b0, 1'b1);
        @(negedge clk); run_add("1021+0212", 8'b01_00_10_01, 8'b00_10_01_10, 8'b10_00_01_00, 1'b0, 1'b0);
        @(negedge clk); run_add("zero",      8'h00,         8'h00,         8'h00,         1'b0, 1'b0);
        @(negedge clk); run_add("inv_b",     8'b01_01_01_01, 8'b11_00_00_00, 8'h00,         1'b0, 1'b1);

        // A second start during the operation must be ignored.
        @(negedge clk);
        a       = 8'b10_10_10_10;
        b       = 8'b10_10_10_10;
        start   = 1'b1;
        ndone   = 0;
        lat     = 0;
        got_sum = 8'h00;
        got_c   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                start = 1'b1;
                a     = 8'b00_00_00_01;
                b     = 8'b00_00_00_01;
            end
            if (k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    lat     = k;
                    got_sum = sum;
                    got_c   = carry_out;
                end
            end
        end
        check("midstart done_count", ndone, 32'd1);
        check("midstart latency", lat, 32'd9);
        check("midstart sum", {24'd0, got_sum}, {24'd0, 8'b10_10_10_01});
        check("midstart carry", {31'd0, got_c}, 32'd1);

        // Reset asserted while in PASS_C of trit 2.
        @(negedge clk);
        a     = 8'b10_10_10_10;
        b     = 8'b10_10_10_10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_rst partial_sum", {24'd0, sum}, {24'd0, 8'b00_00_10_01});
        rst_n = 1'b0;
        #1;
        check("midrst ready", {31'd0, ready}, 32'd1);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst sum", {24'd0, sum}, 32'd0);
        check("midrst carry", {31'd0, carry_out}, 32'd0);
        check("midrst err", {31'd0, err}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst no_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_add("post_rst", 8'b00_00_00_01, 8'b00_00_00_10, 8'b00_00_01_00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ternary_serial_adder
`default_nettype wire
